// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's load/store port.
//
// It provides:
//   - a combinational word read, and
//   - a byte-lane synchronous write.
// A side loader port lets a boot agent preload whole words. After reset, a
// scrub engine zeroes the array before normal service starts. Illegal or
// out-of-range accesses raise a one-cycle registered error pulse.
//
// Parameters
//   DEPTH           number of 32-bit words (power of two, >= 4)
//   BASE_ADDR       byte address of word 0 (aligned to 4*DEPTH)
//   CLEAR_ON_RESET  1: scrub the array after reset, 0: start serving at once
//
// Ports
//   clk_i        in   1   clock
//   rstn_i       in   1   asynchronous active-low reset
//   rw_addr_i    in   32  core byte address (0 when the core has no access)
//   rdata_o      out  32  read word for rw_addr_i, same cycle
//   sel_byte_i   in   4   core byte-lane write enables, 0 = no write
//   wdata_i      in   32  core lane-aligned write data
//   ld_valid_i   in   1   loader request valid
//   ld_ready_o   out  1   loader request accepted when valid && ready
//   ld_addr_i    in   32  loader byte address (bits [1:0] ignored)
//   ld_wdata_i   in   32  loader full-word data
//   init_busy_o  out  1   scrub in progress
//   bus_err_o    out  1   one-cycle error pulse for a dropped access
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] rw_addr_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  sel_byte_i,
    input  logic [31:0] wdata_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        init_busy_o,
    output logic        bus_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Window bounds are held at 33 bits, so a window ending at 2^32 cannot
    // wrap around to zero.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    function automatic logic in_window(input logic [31:0] addr);
        return ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    endfunction

    // Word index relative to the window base. Byte-offset bits drop out in
    // the shift.
    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    // Only single bytes, aligned halves and full words are legal lane masks.
    function automatic logic lanes_legal(input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t          state_q,   state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            bus_err_q, bus_err_d;

    logic [31:0]     mem_q [0:DEPTH-1];

    logic            rw_in_range;
    logic            ld_in_range;
    logic [AW-1:0]   rw_idx;
    logic [AW-1:0]   ld_idx;
    logic            core_wr;
    logic            ld_fire;

    // Single write port shared by scrub, core and loader.
    logic [3:0]      mem_be;
    logic [AW-1:0]   mem_widx;
    logic [31:0]     mem_wdata;

    assign rw_in_range = in_window(rw_addr_i);
    assign ld_in_range = in_window(ld_addr_i);
    assign rw_idx      = word_index(rw_addr_i);
    assign ld_idx      = word_index(ld_addr_i);
    assign core_wr     = (sel_byte_i != 4'b0000);

    // The core owns the write port whenever it drives any lane, so the
    // loader is held off combinationally in those cycles.
    assign ld_ready_o  = (state_q == ST_RUN) && !core_wr;
    assign ld_fire     = ld_valid_i && ld_ready_o;

    assign init_busy_o = (state_q == ST_CLEAR);
    assign bus_err_o   = bus_err_q;

    // The read path shows the stored value before any write this cycle.
    // Nothing is forwarded from the write port.
    assign rdata_o = ((state_q == ST_RUN) && rw_in_range) ? mem_q[rw_idx] : 32'h0;

    // Next-state, scrub counter, write-port steering and error detection.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bus_err_d = 1'b0;
        mem_be    = 4'b0000;
        mem_widx  = rw_idx;
        mem_wdata = wdata_i;

        case (state_q)
            ST_CLEAR: begin
                // One word per cycle. Core traffic is silently ignored here.
                mem_be    = 4'b1111;
                mem_widx  = clr_cnt_q;
                mem_wdata = 32'h0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (core_wr) begin
                    if (lanes_legal(sel_byte_i) && rw_in_range) begin
                        mem_be = sel_byte_i;
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else if (ld_fire) begin
                    if (ld_in_range) begin
                        mem_be    = 4'b1111;
                        mem_widx  = ld_idx;
                        mem_wdata = ld_wdata_i;
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end

                // Address 0 means the core is idle, so it never counts as a
                // stray read.
                if ((rw_addr_i != 32'h0) && !rw_in_range) begin
                    bus_err_d = 1'b1;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Control state is reset asynchronously. A reset mid-scrub restarts the
    // scrub from word 0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // The storage array has no reset. The scrub engine is what clears it.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_be[k]) begin
                mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder with a small array (64 words).
//
// A table of core vectors is applied in a loop. Each vector's expected
// values are queued when it is driven and compared when the DUT answers.
//
// Hand-written sequences cover:
//   - scrub length,
//   - loader/core arbitration,
//   - loader errors, and
//   - reset in the middle of a scrub.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    logic        clk_i;
    logic        rstn_i;
    logic [31:0] rw_addr_i;
    logic [31:0] rdata_o;
    logic [3:0]  sel_byte_i;
    logic [31:0] wdata_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_wdata_i;
    logic        init_busy_o;
    logic        bus_err_o;

    dmem_responder #(
        .DEPTH          (DEPTH),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rw_addr_i   (rw_addr_i),
        .rdata_o     (rdata_o),
        .sel_byte_i  (sel_byte_i),
        .wdata_i     (wdata_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_addr_i   (ld_addr_i),
        .ld_wdata_i  (ld_wdata_i),
        .init_busy_o (init_busy_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        ready;
    } exp_t;

    vec_t vecs [25];
    exp_t sbq [$];

    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits for the next rising edge, then moves 1 time unit past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rw_addr_i  = 32'h0;
        sel_byte_i = 4'b0000;
        wdata_i    = 32'h0;
        ld_valid_i = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rw_addr_i  = v.addr;
        sel_byte_i = v.sel;
        wdata_i    = v.wdata;
        e.rdata    = v.exp_rdata;
        e.err      = v.exp_err;
        e.ready    = (v.sel == 4'b0000);
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_empty[%0d]: got empty queue, expected an entry", idx);
        end else begin
            e = sbq.pop_front();
            #2;
            checkValue($sformatf("vec%0d_rdata", idx), rdata_o, e.rdata);
            checkValue($sformatf("vec%0d_ready", idx), 32'(ld_ready_o), 32'(e.ready));
            tick();
            checkValue($sformatf("vec%0d_err", idx), 32'(bus_err_o), 32'(e.err));
        end
    endtask

    task automatic readCheck(input string name, input logic [31:0] addr,
                             input logic [31:0] expected);
        rw_addr_i  = addr;
        sel_byte_i = 4'b0000;
        #2;
        checkValue(name, rdata_o, expected);
        tick();
        rw_addr_i = 32'h0;
    endtask

    task automatic ldWrite(input logic [31:0] addr, input logic [31:0] data);
        ld_valid_i = 1'b1;
        ld_addr_i  = addr;
        ld_wdata_i = data;
        #2;
        checkValue("ld_ready_idle", 32'(ld_ready_o), 32'd1);
        tick();
        ld_valid_i = 1'b0;
    endtask

    // Counts edges while init_busy_o is high; a correct scrub takes DEPTH edges.
    task automatic waitScrub(input string name);
        int n;
        n = 0;
        while (init_busy_o === 1'b1 && n < DEPTH + 8) begin
            tick();
            n++;
        end
        checkValue({name, "_len"}, 32'(n), 32'(DEPTH));
        checkValue({name, "_ready_after"}, 32'(ld_ready_o), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{BASE + 32'h4,   4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{BASE + 32'h4,   4'b0100, 32'h00AA0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{BASE + 32'h4,   4'b0011, 32'h00001234, 32'hDEAABEEF, 1'b0};
        vecs[3]  = '{BASE + 32'h4,   4'b0000, 32'h00000000, 32'hDEAA1234, 1'b0};
        vecs[4]  = '{TOP,            4'b1111, 32'h12345678, 32'h00000000, 1'b1};
        vecs[5]  = '{BASE,           4'b0110, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[6]  = '{BASE,           4'b0000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[7]  = '{BASE,           4'b1111, 32'h00000005, 32'h00000000, 1'b0};
        vecs[8]  = '{BASE,           4'b1111, 32'h00000001, 32'h00000005, 1'b0};
        vecs[9]  = '{BASE,           4'b0000, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{BASE + 32'hFC,  4'b1000, 32'hAB000000, 32'h00000000, 1'b0};
        vecs[11] = '{BASE + 32'hFE,  4'b0000, 32'h00000000, 32'hAB000000, 1'b0};
        vecs[12] = '{BASE - 32'h4,   4'b0000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[13] = '{32'h0,          4'b0000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[14] = '{BASE + 32'h8,   4'b1100, 32'hCAFE0000, 32'h00000000, 1'b0};
        vecs[15] = '{BASE + 32'h8,   4'b0000, 32'h00000000, 32'hCAFE0000, 1'b0};
        vecs[16] = '{BASE + 32'h8,   4'b1010, 32'hFFFFFFFF, 32'hCAFE0000, 1'b1};
        vecs[17] = '{BASE + 32'h8,   4'b0000, 32'h00000000, 32'hCAFE0000, 1'b0};
        vecs[18] = '{32'hFFFFFFFC,   4'b1111, 32'h00000001, 32'h00000000, 1'b1};
        vecs[19] = '{BASE + 32'h8,   4'b0001, 32'h000000EE, 32'hCAFE0000, 1'b0};
        vecs[20] = '{BASE + 32'h8,   4'b0000, 32'h00000000, 32'hCAFE00EE, 1'b0};
        vecs[21] = '{BASE + 32'h8,   4'b0010, 32'h0000DD00, 32'hCAFE00EE, 1'b0};
        vecs[22] = '{BASE + 32'h8,   4'b0000, 32'h00000000, 32'hCAFEDDEE, 1'b0};
        vecs[23] = '{BASE + 32'h8,   4'b1000, 32'h77000000, 32'hCAFEDDEE, 1'b0};
        vecs[24] = '{BASE + 32'h8,   4'b0000, 32'h00000000, 32'h77FEDDEE, 1'b0};

        idle();
        ld_addr_i  = 32'h0;
        ld_wdata_i = 32'h0;
        rstn_i     = 1'b0;
        #3;
        checkValue("rst_busy",  32'(init_busy_o), 32'd1);
        checkValue("rst_ready", 32'(ld_ready_o),  32'd0);
        checkValue("rst_err",   32'(bus_err_o),   32'd0);
        checkValue("rst_rdata", rdata_o,          32'h0);
        tick();
        tick();
        rstn_i = 1'b1;
        waitScrub("scrub0");

        // Put non-zero data in the array so the next scrub has something to clear.
        ldWrite(BASE + 32'h8,  32'h5A5A5A5A);
        ldWrite(BASE + 32'hFC, 32'hA5A5A5A5);
        checkValue("preload_err", 32'(bus_err_o), 32'd0);
        readCheck("preload_rd8", BASE + 32'h8, 32'h5A5A5A5A);

        // T1: a reset followed by a scrub clears the preloaded word.
        rstn_i = 1'b0;
        rw_addr_i = BASE + 32'h8;
        #1;
        checkValue("t1_rst_busy",  32'(init_busy_o), 32'd1);
        checkValue("t1_rst_rdata", rdata_o,          32'h0);
        idle();
        tick();
        rstn_i = 1'b1;
        waitScrub("t1");
        readCheck("t1_rd8",  BASE + 32'h8,  32'h0);
        readCheck("t1_rdFC", BASE + 32'hFC, 32'h0);

        // T2 lanes, T4 errors, T6 read-before-write: table-driven.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end
        idle();
        tick();
        checkValue("tbl_err_clear", 32'(bus_err_o), 32'd0);

        // T3: loader held off by two core writes, accepted on the third cycle.
        ld_valid_i = 1'b1;
        ld_addr_i  = BASE + 32'h20;
        ld_wdata_i = 32'h11112222;
        rw_addr_i  = BASE + 32'h24;
        sel_byte_i = 4'b1111;
        wdata_i    = 32'hA1A1A1A1;
        #2;
        checkValue("t3_ready_c1", 32'(ld_ready_o), 32'd0);
        tick();
        rw_addr_i  = BASE + 32'h28;
        wdata_i    = 32'hA2A2A2A2;
        #2;
        checkValue("t3_ready_c2", 32'(ld_ready_o), 32'd0);
        tick();
        rw_addr_i  = 32'h0;
        sel_byte_i = 4'b0000;
        wdata_i    = 32'h0;
        #2;
        checkValue("t3_ready_c3", 32'(ld_ready_o), 32'd1);
        tick();
        ld_valid_i = 1'b0;
        checkValue("t3_err", 32'(bus_err_o), 32'd0);
        readCheck("t3_rd20", BASE + 32'h20, 32'h11112222);
        readCheck("t3_rd24", BASE + 32'h24, 32'hA1A1A1A1);
        readCheck("t3_rd28", BASE + 32'h28, 32'hA2A2A2A2);

        // Loader error and core read error in the same cycle give one pulse.
        ld_valid_i = 1'b1;
        ld_addr_i  = TOP;
        ld_wdata_i = 32'hBADBAD00;
        rw_addr_i  = BASE - 32'h4;
        #2;
        checkValue("lderr_ready", 32'(ld_ready_o), 32'd1);
        tick();
        idle();
        checkValue("lderr_pulse", 32'(bus_err_o), 32'd1);
        tick();
        checkValue("lderr_single", 32'(bus_err_o), 32'd0);
        readCheck("lderr_base_kept", BASE, 32'h00000001);

        // T5: core traffic is ignored during the scrub; reset at clr_cnt=17.
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rw_addr_i  = (i % 2 == 0) ? TOP : BASE + 32'h4;
            sel_byte_i = (i % 2 == 0) ? 4'b0110 : 4'b1111;
            wdata_i    = 32'hFFFFFFFF;
            #2;
            checkValue($sformatf("t5_rdata%0d", i), rdata_o,             32'h0);
            checkValue($sformatf("t5_ready%0d", i), 32'(ld_ready_o),     32'd0);
            checkValue($sformatf("t5_busy%0d", i),  32'(init_busy_o),    32'd1);
            tick();
            checkValue($sformatf("t5_err%0d", i),   32'(bus_err_o),      32'd0);
        end
        idle();
        rstn_i = 1'b0;
        #1;
        checkValue("t5_rst_busy",  32'(init_busy_o), 32'd1);
        checkValue("t5_rst_ready", 32'(ld_ready_o),  32'd0);
        checkValue("t5_rst_err",   32'(bus_err_o),   32'd0);
        tick();
        rstn_i = 1'b1;
        waitScrub("t5");
        readCheck("t5_rd4",  BASE + 32'h4,  32'h0);
        readCheck("t5_rd28", BASE + 32'h28, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
